if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the RV32IM pipeline, directly upstream of the instruction cache. Owns the PC and drives the cache address. Holds that address stable across cache misses, applies branch redirects from EX, and loads the IF/ID pipeline register. Also keeps two fetch performance counters.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
CLK  in  1  pipeline clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
BRANCH_TAKEN  in  1  redirect request from EX (branch/jump resolved taken)
BRANCH_TARGET  in  32  redirect target; bits [1:0] ignored, forced to 0
STALL  in  1  hazard-unit stall; hold PC and IF/ID
ICACHE_ADDR  out  32  fetch address to instruction cache (= PC register)
ICACHE_INSTRUCTION  in  32  instruction word from cache
ICACHE_BUSYWAIT  in  1  cache miss in progress
IF_ID_PC  out  32  PC of instruction in IF/ID
IF_ID_PC4  out  32  IF_ID_PC + PC_STEP
IF_ID_INSTRUCTION  out  32  fetched instruction
IF_ID_VALID  out  1  IF/ID holds a real instruction (0 = bubble)
FETCH_COUNT  out  32  instructions delivered to IF/ID
MISS_CYCLES  out  32  rising edges sampled with ICACHE_BUSYWAIT=1

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET is synchronous and active-high.
- Reset:
  - PC = RESET_VECTOR.
  - IF_ID_PC, IF_ID_PC4 and IF_ID_INSTRUCTION = 0.
  - IF_ID_VALID = 0, both counters = 0.
  - State = FETCH, pending-target register = 0.
  - Reset mid-miss abandons the pending redirect. ICACHE_ADDR becomes RESET_VECTOR on the next edge.
- Sampling and timing:
  - ICACHE_ADDR changes only on a rising edge.
  - The cache sequences on the falling edge, so ICACHE_BUSYWAIT and ICACHE_INSTRUCTION are valid at the next rising edge.
  - A hit delivers into IF/ID in 1 cycle.
- Address stability: ICACHE_ADDR must not change while ICACHE_BUSYWAIT=1. This rule is mandatory because the cache tags its refill with the live address.
- States:
  - FETCH: normal operation.
  - MISS_WAIT: cache busy, no redirect pending.
  - REDIRECT_WAIT: cache busy, redirect latched in the pending-target register.
- Per rising edge, not in reset, evaluated in priority order:
  - FETCH or MISS_WAIT, BRANCH_TAKEN=1, BUSYWAIT=0:
    - PC = BRANCH_TARGET.
    - IF_ID_VALID = 0 (flush), even if STALL=1.
    - State = FETCH.
  - FETCH or MISS_WAIT, BRANCH_TAKEN=1, BUSYWAIT=1:
    - Pending = BRANCH_TARGET, PC held.
    - IF_ID_VALID = 0.
    - State = REDIRECT_WAIT.
  - REDIRECT_WAIT, BUSYWAIT=1:
    - PC held, IF_ID_VALID = 0.
    - If BRANCH_TAKEN=1, pending = BRANCH_TARGET (newest wins).
  - REDIRECT_WAIT, BUSYWAIT=0:
    - PC = BRANCH_TARGET if BRANCH_TAKEN=1, else pending.
    - The returned instruction is discarded and IF_ID_VALID = 0.
    - State = FETCH.
  - BUSYWAIT=1 with no branch:
    - State = MISS_WAIT, PC held.
    - IF/ID held if STALL=1, otherwise IF_ID_VALID = 0.
  - BUSYWAIT=0 and STALL=1: PC, IF/ID and state held (state returns to FETCH).
  - Otherwise:
    - IF_ID_PC = PC, IF_ID_PC4 = PC + PC_STEP.
    - IF_ID_INSTRUCTION = ICACHE_INSTRUCTION, IF_ID_VALID = 1.
    - PC = PC + PC_STEP, State = FETCH.
- Arithmetic:
  - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
  - IF_ID_PC4 is computed with the same wrap.
- Counters:
  - FETCH_COUNT increments exactly when IF_ID_VALID is loaded with 1.
  - MISS_CYCLES increments on every edge sampled with BUSYWAIT=1.
  - Both counters wrap at 2^32.

Decomposition:
- Shared package if_pkg holds:
  - state encoding: FETCH=2'b00, MISS_WAIT=2'b01, REDIRECT_WAIT=2'b10;
  - RESET_VECTOR and PC_STEP defaults;
  - the IF/ID field widths.
- One sub-module, if_perf_counter: a 32-bit wrap counter with synchronous clear and enable, instantiated twice.

Test Plan:
- Reset with RESET_VECTOR=0, all cache hits, 4 edges -> IF_ID_PC = 0, 4, 8, C; IF_ID_VALID=1 from the first post-reset edge; FETCH_COUNT=4.
- Miss at PC=0x20, BUSYWAIT high 5 edges -> ICACHE_ADDR stays 0x20 throughout; IF_ID_VALID=0 during the miss; then IF_ID_PC=0x20 with the returned word; MISS_CYCLES=5.
- BRANCH_TAKEN target 0x100 on the 2nd busy edge of a miss at 0x40 -> ICACHE_ADDR stays 0x40 until BUSYWAIT falls; next ICACHE_ADDR=0x100; the 0x40 word never appears with IF_ID_VALID=1.
- STALL=1 for 3 hit cycles at PC=0x10 -> PC and IF/ID unchanged; FETCH_COUNT unchanged; resumes with IF_ID_PC=0x10.
- STALL=1 and BRANCH_TAKEN=1 (target 0x200) together on a hit -> IF_ID_VALID=0; next ICACHE_ADDR=0x200.
- RESET during REDIRECT_WAIT -> next edge ICACHE_ADDR=RESET_VECTOR; pending target never used; counters=0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// default reset vector / PC step, and IF/ID field widths.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH         = 2'b00,
    MISS_WAIT     = 2'b01,
    REDIRECT_WAIT = 2'b10
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT      = 4;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

endpackage

// File: rtl/if_perf_counter.sv
// 32-bit free-running performance counter; clear has priority over enable.
module if_perf_counter (
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, holds the cache address stable during
// misses, defers redirects that arrive mid-miss, and loads the IF/ID register.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BRANCH_TAKEN,
  input  logic [PC_W-1:0]    BRANCH_TARGET,
  input  logic               STALL,
  output logic [PC_W-1:0]    ICACHE_ADDR,
  input  logic [INSTR_W-1:0] ICACHE_INSTRUCTION,
  input  logic               ICACHE_BUSYWAIT,
  output logic [PC_W-1:0]    IF_ID_PC,
  output logic [PC_W-1:0]    IF_ID_PC4,
  output logic [INSTR_W-1:0] IF_ID_INSTRUCTION,
  output logic               IF_ID_VALID,
  output logic [31:0]        FETCH_COUNT,
  output logic [31:0]        MISS_CYCLES
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc, pending, target_aligned, pc_plus_step;

  logic pc_load_target, pc_load_pending, pc_advance;
  logic pending_load, ifid_load, ifid_flush;

  assign target_aligned = BRANCH_TARGET & ~PC_W'(3);
  assign pc_plus_step   = pc + STEP;
  assign ICACHE_ADDR    = pc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    if (state == REDIRECT_WAIT || BRANCH_TAKEN) begin
      state_next = ICACHE_BUSYWAIT ? REDIRECT_WAIT : FETCH;
    end else if (ICACHE_BUSYWAIT) begin
      state_next = MISS_WAIT;
    end
  end

  // The PC never moves while the cache is busy; a redirect seen mid-miss is
  // parked in the pending register and applied when the miss completes.
  always_comb begin
    pc_load_target  = 1'b0;
    pc_load_pending = 1'b0;
    pc_advance      = 1'b0;
    pending_load    = 1'b0;
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;
    if (state != REDIRECT_WAIT && BRANCH_TAKEN) begin
      ifid_flush = 1'b1;
      if (ICACHE_BUSYWAIT) pending_load   = 1'b1;
      else                 pc_load_target = 1'b1;
    end else if (state == REDIRECT_WAIT) begin
      ifid_flush = 1'b1;
      if (ICACHE_BUSYWAIT)   pending_load    = BRANCH_TAKEN;
      else if (BRANCH_TAKEN) pc_load_target  = 1'b1;
      else                   pc_load_pending = 1'b1;
    end else if (ICACHE_BUSYWAIT) begin
      ifid_flush = !STALL;
    end else if (!STALL) begin
      ifid_load  = 1'b1;
      pc_advance = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc                <= RESET_VECTOR;
      pending           <= '0;
      IF_ID_PC          <= '0;
      IF_ID_PC4         <= '0;
      IF_ID_INSTRUCTION <= '0;
      IF_ID_VALID       <= 1'b0;
    end else begin
      if (pc_load_target)       pc <= target_aligned;
      else if (pc_load_pending) pc <= pending;
      else if (pc_advance)      pc <= pc_plus_step;

      if (pending_load) pending <= target_aligned;

      if (ifid_load) begin
        IF_ID_PC          <= pc;
        IF_ID_PC4         <= pc_plus_step;
        IF_ID_INSTRUCTION <= ICACHE_INSTRUCTION;
        IF_ID_VALID       <= 1'b1;
      end else if (ifid_flush) begin
        IF_ID_VALID <= 1'b0;
      end
    end
  end

  if_perf_counter u_fetch_count (
    .clk    (CLK),
    .clear  (RESET),
    .enable (ifid_load),
    .count  (FETCH_COUNT)
  );

  if_perf_counter u_miss_cycles (
    .clk    (CLK),
    .clear  (RESET),
    .enable (ICACHE_BUSYWAIT),
    .count  (MISS_CYCLES)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, branch_taken, stall, busywait;
  logic [31:0] branch_target, instr;
  logic [31:0] icache_addr, if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count, miss_cycles;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_VECTOR (32'h0000_0000),
    .PC_STEP      (4)
  ) dut (
    .CLK                (clk),
    .RESET              (reset),
    .BRANCH_TAKEN       (branch_taken),
    .BRANCH_TARGET      (branch_target),
    .STALL              (stall),
    .ICACHE_ADDR        (icache_addr),
    .ICACHE_INSTRUCTION (instr),
    .ICACHE_BUSYWAIT    (busywait),
    .IF_ID_PC           (if_id_pc),
    .IF_ID_PC4          (if_id_pc4),
    .IF_ID_INSTRUCTION  (if_id_instr),
    .IF_ID_VALID        (if_id_valid),
    .FETCH_COUNT        (fetch_count),
    .MISS_CYCLES        (miss_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_target = '0;
    stall = 1'b0; busywait = 1'b0; instr = 32'h0000_0013;
    step(); step();
    check("rst_addr",  icache_addr, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_pc",    if_id_pc, 32'h0);
    check("rst_pc4",   if_id_pc4, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_fc",    fetch_count, 32'h0);
    check("rst_mc",    miss_cycles, 32'h0);

    // Four hits from reset vector
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr = 32'hA000_0000 + 32'(i);
      step();
      check("hit_pc",    if_id_pc, 32'(i * 4));
      check("hit_pc4",   if_id_pc4, 32'(i * 4 + 4));
      check("hit_instr", if_id_instr, 32'hA000_0000 + 32'(i));
      check("hit_valid", {31'b0, if_id_valid}, 32'h1);
      check("hit_fc",    fetch_count, 32'(i + 1));
    end
    check("hit_addr", icache_addr, 32'h10);

    // Stall three cycles at PC 0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_addr",  icache_addr, 32'h10);
      check("stl_pc",    if_id_pc, 32'h0C);
      check("stl_valid", {31'b0, if_id_valid}, 32'h1);
      check("stl_fc",    fetch_count, 32'd4);
    end
    stall = 1'b0; instr = 32'h1111_1111;
    step();
    check("stl_resume_pc",   if_id_pc, 32'h10);
    check("stl_resume_addr", icache_addr, 32'h14);
    check("stl_resume_fc",   fetch_count, 32'd5);

    step(); step(); step();
    check("pre_miss_addr", icache_addr, 32'h20);
    check("pre_miss_fc",   fetch_count, 32'd8);

    // Five-cycle miss at 0x20
    busywait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("miss_addr",  icache_addr, 32'h20);
      check("miss_valid", {31'b0, if_id_valid}, 32'h0);
      check("miss_mc",    miss_cycles, 32'(i + 1));
    end
    busywait = 1'b0; instr = 32'hDEAD_BEEF;
    step();
    check("miss_done_pc",    if_id_pc, 32'h20);
    check("miss_done_instr", if_id_instr, 32'hDEAD_BEEF);
    check("miss_done_valid", {31'b0, if_id_valid}, 32'h1);
    check("miss_done_addr",  icache_addr, 32'h24);
    check("miss_done_mc",    miss_cycles, 32'd5);
    check("miss_done_fc",    fetch_count, 32'd9);

    for (int i = 0; i < 7; i++) step();
    check("pre_br_addr", icache_addr, 32'h40);
    check("pre_br_fc",   fetch_count, 32'd16);

    // Redirect to 0x100 on the 2nd busy edge of a miss at 0x40
    busywait = 1'b1;
    step();
    check("brm_addr1", icache_addr, 32'h40);
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    check("brm_addr2", icache_addr, 32'h40);
    branch_taken = 1'b0; branch_target = 32'h0;
    step();
    check("brm_addr3", icache_addr, 32'h40);
    check("brm_mc",    miss_cycles, 32'd8);
    busywait = 1'b0; instr = 32'h4040_4040;
    step();
    check("brm_addr4", icache_addr, 32'h100);
    check("brm_valid", {31'b0, if_id_valid}, 32'h0);
    check("brm_fc",    fetch_count, 32'd16);
    instr = 32'h0000_1234;
    step();
    check("brm_pc",    if_id_pc, 32'h100);
    check("brm_instr", if_id_instr, 32'h0000_1234);
    check("brm_fc2",   fetch_count, 32'd17);

    // Stall and branch together on a hit; low target bits forced to zero
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h203;
    step();
    check("stbr_valid", {31'b0, if_id_valid}, 32'h0);
    check("stbr_addr",  icache_addr, 32'h200);
    check("stbr_fc",    fetch_count, 32'd17);
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    step();
    check("stbr_pc", if_id_pc, 32'h200);
    check("stbr_fc2", fetch_count, 32'd18);

    // Reset while a redirect is pending
    busywait = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    step();
    check("rrw_addr", icache_addr, 32'h204);
    branch_taken = 1'b0; branch_target = 32'h0; reset = 1'b1;
    step();
    check("rrw_addr_rst", icache_addr, 32'h0);
    check("rrw_fc",       fetch_count, 32'h0);
    check("rrw_mc",       miss_cycles, 32'h0);
    reset = 1'b0; busywait = 1'b0;
    step();
    check("rrw_addr_after", icache_addr, 32'h4);
    check("rrw_pc",         if_id_pc, 32'h0);
    check("rrw_fc2",        fetch_count, 32'd1);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    check("wrap_addr0", icache_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step();
    check("wrap_pc",   if_id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4",  if_id_pc4, 32'h0);
    check("wrap_addr", icache_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
